fft_spectral_mac: RTL

- Sits between the forward FFT wrapper and the inverse FFT wrapper in the FFT-based convolution layer.
- Captures each N-bin spectrum frame that the forward FFT emits.
- Multiplies every bin by a kernel spectrum bin read from weight memory, and accumulates the products over num_chan input channels.
- Presents the accumulated spectrum to the IFFT using the same next-pulse-then-data protocol the FFT cores use.

---
 rtl/fft_spectral_mac.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fft_spectral_mac.sv
// fft_spectral_mac: sits between the forward FFT and the inverse FFT of the
// FFT-based convolution layer. Each captured N-bin spectrum is multiplied bin
// by bin with a kernel spectrum fetched from weight memory, and the products
// are accumulated over the configured number of input channels. The finished
// sum is handed downstream with the FFT cores' next-pulse-then-data protocol.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous, active-high reset
//   num_chan_i   channels per output frame (0 behaves as 1), latched on channel 0
//   in_next_i    one-cycle pulse from the upstream FFT; in_data_i valid next cycle
//   in_data_i    N bins, bin k at [64k+63:64k], {re[31:0], im[31:0]}
//   w_rd_o       weight read strobe
//   w_chan_o     weight channel address
//   w_bin_o      weight bin address
//   w_data_i     weight bin {re, im}, valid one cycle after w_rd_o
//   out_next_o   one-cycle pulse to the downstream IFFT
//   out_data_o   accumulated spectrum, valid from the cycle after out_next_o
//   busy_o       high whenever not idle
//   drop_o       sticky: a frame arrived while busy
//   ovf_o        sticky: an accumulator saturated
module fft_spectral_mac #(
  parameter int unsigned N      = 8,
  parameter int unsigned FRAC   = 16,
  parameter int unsigned CHAN_W = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [CHAN_W-1:0]     num_chan_i,
  input  logic                  in_next_i,
  input  logic [64*N-1:0]       in_data_i,
  output logic                  w_rd_o,
  output logic [CHAN_W-1:0]     w_chan_o,
  output logic [$clog2(N)-1:0]  w_bin_o,
  input  logic [63:0]           w_data_i,
  output logic                  out_next_o,
  output logic [64*N-1:0]       out_data_o,
  output logic                  busy_o,
  output logic                  drop_o,
  output logic                  ovf_o
);

  localparam int unsigned BinW = $clog2(N);
  localparam int unsigned PhW  = BinW + 1;

  typedef enum logic [1:0] {StIdle, StCap, StMac, StEmit} state_e;

  state_e            state_q;
  logic [PhW-1:0]    phase_q;
  logic [CHAN_W-1:0] chan_q;
  logic [CHAN_W-1:0] nchan_q;
  logic [63:0]       cap_q [N];
  logic [63:0]       acc_q [N];
  logic [64*N-1:0]   out_q;
  logic              drop_q;
  logic              ovf_q;

  // Datapath for the bin being combined this cycle (phase b works on bin b-1,
  // because the weight requested in phase b-1 arrives in phase b).
  logic [BinW-1:0]     bin_idx;
  logic signed [31:0]  a_re, a_im, w_re, w_im, acc_re, acc_im;
  logic signed [63:0]  p_ac, p_bd, p_ad, p_bc;
  logic signed [64:0]  re_sum, im_sum, re_t, im_t;
  logic signed [65:0]  re_base, im_base, re_x, im_x;
  logic                re_ovf, im_ovf, first_chan;
  logic [31:0]         re_sat, im_sat;

  always_comb begin
    bin_idx    = BinW'(phase_q - PhW'(1));
    first_chan = (chan_q == '0);
    a_re       = cap_q[bin_idx][63:32];
    a_im       = cap_q[bin_idx][31:0];
    acc_re     = acc_q[bin_idx][63:32];
    acc_im     = acc_q[bin_idx][31:0];
    w_re       = w_data_i[63:32];
    w_im       = w_data_i[31:0];
    p_ac       = 64'(a_re) * 64'(w_re);
    p_bd       = 64'(a_im) * 64'(w_im);
    p_ad       = 64'(a_re) * 64'(w_im);
    p_bc       = 64'(a_im) * 64'(w_re);
    re_sum     = 65'(p_ac) - 65'(p_bd);
    im_sum     = 65'(p_ad) + 65'(p_bc);
    re_t       = re_sum >>> FRAC;
    im_t       = im_sum >>> FRAC;
    re_base    = first_chan ? 66'sd0 : 66'(acc_re);
    im_base    = first_chan ? 66'sd0 : 66'(acc_im);
    re_x       = 66'(re_t) + re_base;
    im_x       = 66'(im_t) + im_base;
    // Fits in 32 bits only when bits 65..31 are all copies of the sign.
    re_ovf     = (re_x[65:31] != {35{re_x[31]}});
    im_ovf     = (im_x[65:31] != {35{im_x[31]}});
    re_sat     = re_ovf ? (re_x[65] ? 32'h8000_0000 : 32'h7FFF_FFFF) : re_x[31:0];
    im_sat     = im_ovf ? (im_x[65] ? 32'h8000_0000 : 32'h7FFF_FFFF) : im_x[31:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      phase_q <= '0;
      chan_q  <= '0;
      nchan_q <= '0;
      out_q   <= '0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        cap_q[k] <= '0;
        acc_q[k] <= '0;
      end
    end else begin
      if (in_next_i && (state_q != StIdle)) drop_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (in_next_i) state_q <= StCap;
        end
        StCap: begin
          for (int k = 0; k < N; k++) cap_q[k] <= in_data_i[64*k +: 64];
          if (chan_q == '0) begin
            nchan_q <= (num_chan_i == '0) ? CHAN_W'(1) : num_chan_i;
          end
          phase_q <= '0;
          state_q <= StMac;
        end
        StMac: begin
          if (phase_q != '0) begin
            acc_q[bin_idx] <= {re_sat, im_sat};
            if (re_ovf || im_ovf) ovf_q <= 1'b1;
          end
          if (phase_q == PhW'(N)) begin
            if (chan_q == nchan_q - CHAN_W'(1)) begin
              state_q <= StEmit;
            end else begin
              chan_q  <= chan_q + CHAN_W'(1);
              state_q <= StIdle;
            end
          end else begin
            phase_q <= phase_q + PhW'(1);
          end
        end
        StEmit: begin
          for (int k = 0; k < N; k++) out_q[64*k +: 64] <= acc_q[k];
          chan_q  <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = (state_q != StIdle);
  assign out_next_o = (state_q == StEmit);
  assign w_rd_o     = (state_q == StMac) && (phase_q < PhW'(N));
  assign w_bin_o    = w_rd_o ? phase_q[BinW-1:0] : '0;
  assign w_chan_o   = chan_q;
  assign out_data_o = out_q;
  assign drop_o     = drop_q;
  assign ovf_o      = ovf_q;

endmodule
